// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline boundary register with bubble, hold, flush and stall counter
module pipe_stage_reg #(
    parameter int                     DATA_W   = 128,
    parameter int                     STICKY_W = 1,
    parameter int                     EXC_W    = 5,
    parameter logic [EXC_W-1:0]       EC_NONE  = '0,
    parameter logic [DATA_W-1:0]      BUBBLE   = '0,
    parameter int                     STALL_W  = 6,
    parameter int                     STAGE    = 2,
    parameter int                     CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [STICKY_W-1:0] in_sticky,
    input  logic [EXC_W-1:0]    in_exc,
    input  logic [31:0]         in_epc,
    input  logic [31:0]         in_badvaddr,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [STICKY_W-1:0] out_sticky,
    output logic [EXC_W-1:0]    out_exc,
    output logic [31:0]         out_epc,
    output logic [31:0]         out_badvaddr,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                up;
    logic                dn;
    logic                unused_stall;

    logic                valid_q,  valid_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic [STICKY_W-1:0] sticky_q, sticky_d;
    logic [EXC_W-1:0]    exc_q,    exc_d;
    logic [31:0]         epc_q,    epc_d;
    logic [31:0]         bad_q,    bad_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [CNT_W-1:0]    cnt_inc;

    assign up           = stall[STAGE];
    assign dn           = stall[STAGE+1];
    assign unused_stall = ^stall;

    // Saturating increment shared by the bubble and hold cases
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        sticky_d = sticky_q;
        exc_d    = exc_q;
        epc_d    = epc_q;
        bad_d    = bad_q;
        cnt_d    = cnt_q;

        if (flush) begin
            valid_d  = 1'b0;
            data_d   = BUBBLE;
            sticky_d = '0;
            exc_d    = EC_NONE;
            epc_d    = '0;
            bad_d    = '0;
            cnt_d    = '0;
        end else if (up && !dn) begin
            // Sticky sideband deliberately survives the inserted bubble
            valid_d  = 1'b0;
            data_d   = BUBBLE;
            exc_d    = EC_NONE;
            epc_d    = '0;
            bad_d    = '0;
            cnt_d    = cnt_inc;
        end else if (up) begin
            cnt_d    = cnt_inc;
        end else begin
            // Illegal up=0/dn=1 lands here and behaves as a normal advance
            sticky_d = in_sticky;
            cnt_d    = '0;
            if (in_valid) begin
                valid_d = 1'b1;
                data_d  = in_data;
                exc_d   = in_exc;
                epc_d   = in_epc;
                bad_d   = in_badvaddr;
            end else begin
                valid_d = 1'b0;
                data_d  = BUBBLE;
                exc_d   = EC_NONE;
                epc_d   = '0;
                bad_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            data_q   <= BUBBLE;
            sticky_q <= '0;
            exc_q    <= EC_NONE;
            epc_q    <= '0;
            bad_q    <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            sticky_q <= sticky_d;
            exc_q    <= exc_d;
            epc_q    <= epc_d;
            bad_q    <= bad_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_sticky   = sticky_q;
    assign out_exc      = exc_q;
    assign out_epc      = epc_q;
    assign out_badvaddr = bad_q;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized self-checking bench for pipe_stage_reg against a behavioural model
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic         flush;
    logic         in_valid;
    logic [127:0] in_data;
    logic [0:0]   in_sticky;
    logic [4:0]   in_exc;
    logic [31:0]  in_epc;
    logic [31:0]  in_badvaddr;

    logic         out_valid,  s_valid;
    logic [127:0] out_data,   s_data;
    logic [0:0]   out_sticky, s_sticky;
    logic [4:0]   out_exc,    s_exc;
    logic [31:0]  out_epc,    s_epc;
    logic [31:0]  out_badvaddr, s_bad;
    logic [7:0]   stall_cnt;
    logic [2:0]   s_cnt;

    int checks   = 0;
    int failures = 0;
    bit illegal_ok = 1'b0;

    logic         e_valid;
    logic [127:0] e_data;
    logic         e_sticky;
    logic [4:0]   e_exc;
    logic [31:0]  e_epc, e_bad;
    int           e_cnt, e_cnt3;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_sticky(in_sticky),
        .in_exc(in_exc), .in_epc(in_epc), .in_badvaddr(in_badvaddr),
        .out_valid(out_valid), .out_data(out_data), .out_sticky(out_sticky),
        .out_exc(out_exc), .out_epc(out_epc), .out_badvaddr(out_badvaddr),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_sticky(in_sticky),
        .in_exc(in_exc), .in_epc(in_epc), .in_badvaddr(in_badvaddr),
        .out_valid(s_valid), .out_data(s_data), .out_sticky(s_sticky),
        .out_exc(s_exc), .out_epc(s_epc), .out_badvaddr(s_bad),
        .stall_cnt(s_cnt)
    );

    always @(posedge clk) begin
        if (rst === 1'b1 && stall[2] === 1'b0 && stall[3] === 1'b1) begin
            assert (illegal_ok) else begin
                failures++;
                $error("FAIL illegal_stall observed=%b expected=contiguous prefix", stall);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid",  128'(out_valid),    128'(e_valid));
        chk("data",   out_data,           e_data);
        chk("sticky", 128'(out_sticky),   128'(e_sticky));
        chk("exc",    128'(out_exc),      128'(e_exc));
        chk("epc",    128'(out_epc),      128'(e_epc));
        chk("bad",    128'(out_badvaddr), 128'(e_bad));
        chk("cnt",    128'(stall_cnt),    128'(e_cnt));
        chk("cnt3",   128'(s_cnt),        128'(e_cnt3));
    endtask

    task automatic model_clear(input bit with_sticky);
        e_valid = 1'b0;
        e_data  = '0;
        e_exc   = '0;
        e_epc   = '0;
        e_bad   = '0;
        if (with_sticky) begin
            e_sticky = 1'b0;
            e_cnt    = 0;
            e_cnt3   = 0;
        end
    endtask

    task automatic model_edge();
        if (flush) begin
            model_clear(1'b1);
        end else if (stall[2]) begin
            if (!stall[3]) model_clear(1'b0);
            if (e_cnt < 255) e_cnt++;
            if (e_cnt3 < 7) e_cnt3++;
        end else begin
            e_sticky = in_sticky[0];
            e_cnt    = 0;
            e_cnt3   = 0;
            if (in_valid) begin
                e_valid = 1'b1;
                e_data  = in_data;
                e_exc   = in_exc;
                e_epc   = in_epc;
                e_bad   = in_badvaddr;
            end else begin
                model_clear(1'b0);
            end
        end
    endtask

    task automatic rand_inputs();
        in_valid    = 1'($urandom_range(0, 1));
        in_data     = {$urandom, $urandom, $urandom, $urandom};
        in_sticky   = 1'($urandom_range(0, 1));
        in_exc      = 5'($urandom_range(0, 31));
        in_epc      = $urandom;
        in_badvaddr = $urandom;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0;
        rand_inputs();
        in_valid = 1'b1;
        model_clear(1'b1);
        step();

        // asynchronous reset between edges with random inputs present
        rand_inputs();
        #2 rst = 1'b0;
        #1 model_clear(1'b1);
        check_all();
        @(posedge clk);
        #1 rst = 1'b1;
        check_all();

        stall = '0; in_valid = 1'b1; in_data = 128'h1234; in_exc = 5'd3;
        in_epc = $urandom; in_badvaddr = $urandom; in_sticky = 1'b0;
        step();
        chk("adv_data", out_data, 128'h1234);
        chk("adv_exc", 128'(out_exc), 128'd3);

        in_sticky = 1'b1;
        step();
        stall = 6'b000111;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step();
            chk("bubble_cnt", 128'(stall_cnt), 128'(i + 1));
            chk("bubble_sticky", 128'(out_sticky), 128'd1);
        end

        stall = '0; in_valid = 1'b1; in_data = 128'hA5A5;
        step();
        stall = 6'b001111;
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            step();
        end
        chk("hold_data", out_data, 128'hA5A5);
        chk("hold_cnt", 128'(stall_cnt), 128'd4);
        stall = '0; rand_inputs(); in_valid = 1'b1;
        step();
        chk("release_cnt", 128'(stall_cnt), 128'd0);

        stall = 6'b001111; flush = 1'b1; rand_inputs(); in_valid = 1'b1;
        step();
        flush = 1'b0;

        // async reset during a hold
        stall = '0; rand_inputs(); in_valid = 1'b1; in_sticky = 1'b1;
        step();
        stall = 6'b001111;
        step();
        #3 rst = 1'b0;
        #1 model_clear(1'b1);
        check_all();
        @(posedge clk);
        #1 rst = 1'b1;
        check_all();

        // illegal up=0/dn=1 treated as advance
        illegal_ok = 1'b1;
        stall = 6'b001000; rand_inputs(); in_valid = 1'b1;
        step();
        illegal_ok = 1'b0;
        stall = '0;
        #1;

        for (int i = 0; i < 400; i++) begin
            stall = 6'((1 << $urandom_range(0, 6)) - 1);
            flush = ($urandom_range(0, 15) == 0);
            rand_inputs();
            step();
        end
        flush = 1'b0;

        stall = 6'b001111;
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step();
        end
        chk("sat_cnt8", 128'(stall_cnt), 128'd255);
        chk("sat_cnt3", 128'(s_cnt), 128'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
